// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM state type and GPIO edge-select encodings for pwm_mchan.
package pwm_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} pwm_st_e;
   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;
endpackage

// File: rtl/pwm_dtime.sv
// pwm_dtime: delays the rising edge of one registered level by dtime cycles; shorter pulses vanish.
module pwm_dtime
   import pwm_pkg::*;
(
   input  logic       mclk,
   input  logic       h_reset,
   input  logic       in_lvl,
   input  logic [7:0] dtime,
   output logic       out_lvl
);
   logic [7:0] cnt;
   always_ff @(posedge mclk) begin
      if (h_reset) begin
         cnt     <= 8'd0;
         out_lvl <= 1'b0;
      end else if (!in_lvl) begin
         cnt     <= dtime;
         out_lvl <= 1'b0;
      end else begin
         cnt     <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
         out_lvl <= (cnt == 8'd0);
      end
   end
endmodule

// File: rtl/pwm_mchan.sv
// pwm_mchan: multi-channel PWM on one prescaled timebase with shadowed period/compare.
// Define PWM_DEADTIME_EN for dead-time complementary outputs on pwm_n_o.
module pwm_mchan
   import pwm_pkg::*;
#(
   parameter int CNT_W  = 16,
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 8
) (
   input  logic                    mclk,
   input  logic                    h_reset,
   input  logic                    cfg_pwm_enb,
   input  logic                    cfg_pwm_run,
   input  logic [DIV_W-1:0]        cfg_pwm_div,
   input  logic                    cfg_pwm_updn,
   input  logic                    cfg_pwm_oneshot,
   input  logic [7:0]              cfg_pwm_rpt,
   input  logic                    cfg_pwm_gpio_enb,
   input  logic                    cfg_pwm_gpio_edge,
   input  logic [2:0]              cfg_pwm_gpio_sel,
   input  logic [7:0]              pad_gpio,
   input  logic [CNT_W-1:0]        cfg_pwm_period,
   input  logic [NUM_CH*CNT_W-1:0] cfg_pwm_comp,
   input  logic [NUM_CH-1:0]       cfg_pwm_inv,
   input  logic [7:0]              cfg_pwm_dtime,
   output logic [NUM_CH-1:0]       pwm_o,
   output logic [NUM_CH-1:0]       pwm_n_o,
   output logic                    pwm_prd_pe,
   output logic                    pwm_done,
   output logic                    pwm_busy
);
   pwm_st_e                 st, st_n;
   logic [CNT_W-1:0]        cnt, cnt_n, per_sh;
   logic [NUM_CH*CNT_W-1:0] comp_sh;
   logic [DIV_W-1:0]        presc;
   logic [7:0]              rpt_cnt;
   logic                    dir, dir_n, tick, ev, fin, live, ld;
   logic                    g_s, g_p, g_edge;
   logic [NUM_CH-1:0]       raw, pwm_d;

   assign live   = cfg_pwm_enb & cfg_pwm_run;
   assign g_edge = (cfg_pwm_gpio_edge == EDGE_FALL) ? (g_p & ~g_s) : (~g_p & g_s);
   assign tick   = (st == RUN) && (presc == '0);
   assign fin    = ev & cfg_pwm_oneshot & (rpt_cnt == cfg_pwm_rpt);
   assign ld     = (st == IDLE) | ev | ((st == ARMED) & g_edge);

   // center mode: the downward step that lands on 0 is the period event and turns the count upward
   always_comb begin
      cnt_n = cnt;
      dir_n = dir;
      ev    = 1'b0;
      if (tick) begin
         if (!cfg_pwm_updn) begin
            ev    = (cnt >= per_sh);
            cnt_n = ev ? '0 : cnt + CNT_W'(1);
         end else if (per_sh == '0) begin
            ev    = 1'b1;
            cnt_n = '0;
            dir_n = 1'b0;
         end else if (dir || cnt >= per_sh) begin
            ev    = (cnt <= CNT_W'(1));
            cnt_n = ev ? '0 : cnt - CNT_W'(1);
            dir_n = !ev;
         end else begin
            cnt_n = cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      st_n     = st;
      pwm_busy = (st == ARMED) || (st == RUN);
      if (!live) begin
         st_n = IDLE;
      end else begin
         case (st)
            IDLE:  st_n = cfg_pwm_gpio_enb ? ARMED : RUN;
            ARMED: st_n = g_edge ? RUN : ARMED;
            RUN:   st_n = fin ? DONE : RUN;
            DONE:  st_n = DONE;
         endcase
      end
   end

   always_ff @(posedge mclk) begin
      if (h_reset) begin
         st         <= IDLE;
         cnt        <= '0;
         dir        <= 1'b0;
         presc      <= '0;
         rpt_cnt    <= 8'd0;
         per_sh     <= '0;
         comp_sh    <= '0;
         g_s        <= 1'b0;
         g_p        <= 1'b0;
         pwm_prd_pe <= 1'b0;
         pwm_done   <= 1'b0;
      end else begin
         st         <= st_n;
         g_s        <= pad_gpio[cfg_pwm_gpio_sel];
         g_p        <= g_s;
         pwm_prd_pe <= ev & live;
         pwm_done   <= fin & live;
         if (ld) begin
            per_sh  <= cfg_pwm_period;
            comp_sh <= cfg_pwm_comp;
         end
         if (st != RUN) begin
            cnt     <= '0;
            dir     <= 1'b0;
            presc   <= '0;
            rpt_cnt <= 8'd0;
         end else begin
            cnt     <= cnt_n;
            dir     <= dir_n;
            presc   <= (presc == cfg_pwm_div) ? '0 : presc + DIV_W'(1);
            rpt_cnt <= ev ? rpt_cnt + 8'd1 : rpt_cnt;
         end
      end
   end

   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_CH; i++) raw[i] = cnt < comp_sh[i*CNT_W +: CNT_W];
   end

   assign pwm_d = (st == RUN) ? raw ^ cfg_pwm_inv : cfg_pwm_inv;

`ifdef PWM_DEADTIME_EN
   for (genvar g = 0; g < NUM_CH; g++) begin : g_dt
      pwm_dtime u_dt_p (
         .mclk    (mclk),
         .h_reset (h_reset),
         .in_lvl  (pwm_d[g]),
         .dtime   (cfg_pwm_dtime),
         .out_lvl (pwm_o[g])
      );
      pwm_dtime u_dt_n (
         .mclk    (mclk),
         .h_reset (h_reset),
         .in_lvl  (~pwm_d[g]),
         .dtime   (cfg_pwm_dtime),
         .out_lvl (pwm_n_o[g])
      );
   end
`else
   logic unused_dtime;
   assign unused_dtime = ^cfg_pwm_dtime;
   assign pwm_n_o      = '0;
   always_ff @(posedge mclk) begin
      if (h_reset) pwm_o <= '0;
      else pwm_o <= pwm_d;
   end
`endif
endmodule

// File: tb/tb_pwm_mchan.sv
// tb_pwm_mchan: scoreboard bench for pwm_mchan; expectations queued per cycle, compared after each edge.
module tb_pwm_mchan;
   logic        mclk = 1'b0;
   logic        h_reset = 1'b1;
   logic        cfg_pwm_enb = 1'b0, cfg_pwm_run = 1'b0, cfg_pwm_updn = 1'b0, cfg_pwm_oneshot = 1'b0;
   logic [7:0]  cfg_pwm_div = 8'd0, cfg_pwm_rpt = 8'd0, cfg_pwm_dtime = 8'd0, pad_gpio = 8'd0;
   logic        cfg_pwm_gpio_enb = 1'b0, cfg_pwm_gpio_edge = 1'b0;
   logic [2:0]  cfg_pwm_gpio_sel = 3'd0;
   logic [15:0] cfg_pwm_period = 16'd0;
   logic [63:0] cfg_pwm_comp = 64'd0;
   logic [3:0]  cfg_pwm_inv = 4'b1000;
   logic [3:0]  pwm_o, pwm_n_o;
   logic        pwm_prd_pe, pwm_done, pwm_busy;

`ifdef PWM_DEADTIME_EN
   localparam logic [3:0] NZ = 4'h0;
`else
   localparam logic [3:0] NZ = 4'hF;
`endif

   typedef struct {
      logic [3:0] om, o, nm, n;
      logic       pe, dn, bz;
   } exp_t;

   exp_t  sb[$];
   int    total = 0, bad = 0;
   string phase = "reset";
   int    tri_cnt[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

   pwm_mchan u_dut (
      .mclk              (mclk),
      .h_reset           (h_reset),
      .cfg_pwm_enb       (cfg_pwm_enb),
      .cfg_pwm_run       (cfg_pwm_run),
      .cfg_pwm_div       (cfg_pwm_div),
      .cfg_pwm_updn      (cfg_pwm_updn),
      .cfg_pwm_oneshot   (cfg_pwm_oneshot),
      .cfg_pwm_rpt       (cfg_pwm_rpt),
      .cfg_pwm_gpio_enb  (cfg_pwm_gpio_enb),
      .cfg_pwm_gpio_edge (cfg_pwm_gpio_edge),
      .cfg_pwm_gpio_sel  (cfg_pwm_gpio_sel),
      .pad_gpio          (pad_gpio),
      .cfg_pwm_period    (cfg_pwm_period),
      .cfg_pwm_comp      (cfg_pwm_comp),
      .cfg_pwm_inv       (cfg_pwm_inv),
      .cfg_pwm_dtime     (cfg_pwm_dtime),
      .pwm_o             (pwm_o),
      .pwm_n_o           (pwm_n_o),
      .pwm_prd_pe        (pwm_prd_pe),
      .pwm_done          (pwm_done),
      .pwm_busy          (pwm_busy)
   );

   always #5 mclk = ~mclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic push(input logic [3:0] om, o, nm, n, input logic pe, dn, bz);
      exp_t e;
      e.om = om; e.o = o; e.nm = nm; e.n = n; e.pe = pe; e.dn = dn; e.bz = bz;
      sb.push_back(e);
   endtask

   task automatic drain(input int cycles);
      exp_t e;
      for (int k = 0; k < cycles; k++) begin
         step();
         if (sb.size() == 0) begin
            chk({phase, ".sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk({phase, ".o"}, 32'(pwm_o & e.om), 32'(e.o));
            chk({phase, ".n"}, 32'(pwm_n_o & e.nm), 32'(e.n));
            chk({phase, ".pe"}, 32'(pwm_prd_pe), 32'(e.pe));
            chk({phase, ".dn"}, 32'(pwm_done), 32'(e.dn));
            chk({phase, ".bz"}, 32'(pwm_busy), 32'(e.bz));
         end
      end
   endtask

   initial begin
      int kk;
      repeat (3) step();
      chk("reset.o", 32'(pwm_o), 32'd0);
      chk("reset.n", 32'(pwm_n_o), 32'd0);
      chk("reset.pe", 32'(pwm_prd_pe), 32'd0);
      chk("reset.dn", 32'(pwm_done), 32'd0);
      chk("reset.bz", 32'(pwm_busy), 32'd0);

      h_reset = 1'b0;
      cfg_pwm_enb = 1'b1;
      cfg_pwm_period = 16'd9;
      cfg_pwm_comp = {16'd9, 16'd10, 16'd0, 16'd3};
      repeat (2) step();
      chk("idle.o", 32'(pwm_o), 32'h8);
      chk("idle.bz", 32'(pwm_busy), 32'd0);

      phase = "edge";
      cfg_pwm_run = 1'b1;
      push(4'hF, 4'b1000, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 30; m++) begin
         kk = (m - 1) % 10;
         push(4'hF, {kk == 9, 1'b1, 1'b0, kk < 3}, NZ, 4'h0, m % 10 == 0, 1'b0, 1'b1);
      end
      drain(31);
      cfg_pwm_run = 1'b0;
      repeat (2) step();

      phase = "shadow";
      cfg_pwm_comp[15:0] = 16'd5;
      cfg_pwm_run = 1'b1;
      push(4'h1, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 40; m++)
         push(4'h1, {3'b0, ((m - 1) % 10) < (m >= 21 ? 7 : 5)}, NZ, 4'h0, m % 10 == 0, 1'b0, 1'b1);
      drain(14);
      cfg_pwm_comp[15:0] = 16'd7;
      drain(27);
      cfg_pwm_run = 1'b0;
      repeat (2) step();

      phase = "center";
      cfg_pwm_updn = 1'b1;
      cfg_pwm_period = 16'd4;
      cfg_pwm_comp[31:16] = 16'd2;
      step();
      cfg_pwm_run = 1'b1;
      push(4'h2, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 24; m++)
         push(4'h2, {2'b0, tri_cnt[(m - 1) % 8] < 2, 1'b0}, NZ, 4'h0, m % 8 == 0, 1'b0, 1'b1);
      drain(25);
      cfg_pwm_run = 1'b0;
      cfg_pwm_updn = 1'b0;
      repeat (2) step();

      phase = "oneshot";
      cfg_pwm_oneshot = 1'b1;
      cfg_pwm_rpt = 8'd2;
      cfg_pwm_period = 16'd3;
      cfg_pwm_comp[15:0] = 16'd2;
      cfg_pwm_inv = 4'b0001;
      step();
      cfg_pwm_run = 1'b1;
      push(4'h1, 4'h1, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 20; m++)
         push(4'h1, {3'b0, m >= 13 ? 1'b1 : !(((m - 1) % 4) < 2)}, NZ, 4'h0,
              m == 4 || m == 8 || m == 12, m == 12, m < 12);
      drain(21);
      cfg_pwm_run = 1'b0;
      push(4'h1, 4'h1, NZ, 4'h0, 1'b0, 1'b0, 1'b0);
      drain(1);
      cfg_pwm_oneshot = 1'b0;
      cfg_pwm_inv = 4'b0000;
      cfg_pwm_period = 16'd9;
      cfg_pwm_comp[15:0] = 16'd3;
      repeat (2) step();

      phase = "gpio";
      cfg_pwm_gpio_enb = 1'b1;
      cfg_pwm_gpio_edge = 1'b1;
      cfg_pwm_gpio_sel = 3'd5;
      repeat (2) step();
      cfg_pwm_run = 1'b1;
      for (int m = 0; m < 5; m++) push(4'h1, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      drain(5);
      pad_gpio = 8'h20;
      for (int m = 0; m < 5; m++) push(4'h1, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      drain(5);
      pad_gpio = 8'h00;
      for (int k = 1; k <= 15; k++)
         push(4'h1, {3'b0, k >= 3 && ((k - 3) % 10) < 3}, NZ, 4'h0, k == 12, 1'b0, 1'b1);
      drain(15);
      cfg_pwm_run = 1'b0;
      cfg_pwm_gpio_enb = 1'b0;
      repeat (2) step();

      phase = "enb_drop";
      cfg_pwm_run = 1'b1;
      push(4'h1, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 9; m++)
         push(4'h1, {3'b0, ((m - 1) % 10) < 3}, NZ, 4'h0, 1'b0, 1'b0, 1'b1);
      drain(10);
      cfg_pwm_enb = 1'b0;
      push(4'h1, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b0);
      push(4'h1, 4'h0, NZ, 4'h0, 1'b0, 1'b0, 1'b0);
      drain(2);
      cfg_pwm_enb = 1'b1;
      cfg_pwm_run = 1'b0;
      repeat (2) step();

`ifdef PWM_DEADTIME_EN
      phase = "dtime";
      cfg_pwm_dtime = 8'd2;
      cfg_pwm_comp[15:0] = 16'd5;
      step();
      cfg_pwm_run = 1'b1;
      push(4'h1, 4'h0, 4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
      for (int m = 1; m <= 30; m++) begin
         kk = (m - 1) % 10;
         push(4'h1, {3'b0, kk >= 2 && kk <= 4}, 4'h1, {3'b0, kk >= 7}, m % 10 == 0, 1'b0, 1'b1);
      end
      drain(31);
      cfg_pwm_run = 1'b0;
      step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
